// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and the default frame
// geometry used by the baud generator, transmitter and receiver.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: tick/line inputs, byte outputs, status and
// the FSM state for observation.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
);

   // Handshake: data_valid and frame_error are single-clk pulses with no
   // ready/back-pressure; the consumer must capture data_out in the pulse
   // cycle (or at least before the next good frame overwrites it).
   logic                 sample_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_error;
   logic                 rx_busy;
   rx_state_e            rx_state;

   modport master (
      output sample_tick,
      output rx,
      input  data_out,
      input  data_valid,
      input  frame_error,
      input  rx_busy,
      input  rx_state
   );

   modport slave (
      input  sample_tick,
      input  rx,
      output data_out,
      output data_valid,
      output frame_error,
      output rx_busy,
      output rx_state
   );

endinterface : uart_rx_if

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// take RESET_VAL on reset so an idle-high line does not look like an edge.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, centre sampling of each
// bit, one-clk valid/framing-error pulses and break suppression.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e            state,       state_nxt;
   logic [TICK_W-1:0]    tick_cnt,    tick_cnt_nxt;
   logic [BIT_W-1:0]     bit_idx,     bit_idx_nxt;
   logic [DATA_BITS-1:0] shift_reg,   shift_reg_nxt;
   logic [DATA_BITS-1:0] data_q,      data_nxt;
   logic                 valid_q,     valid_nxt;
   logic                 ferr_q,      ferr_nxt;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= RX_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         tick_cnt  <= tick_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_reg_nxt;
         data_q    <= data_nxt;
         valid_q   <= valid_nxt;
         ferr_q    <= ferr_nxt;
      end
   end

   // Pulses default low every clk, so they last one cycle even when
   // sample_tick is held high.
   always_comb begin
      state_nxt     = state;
      tick_cnt_nxt  = tick_cnt;
      bit_idx_nxt   = bit_idx;
      shift_reg_nxt = shift_reg;
      data_nxt      = data_q;
      valid_nxt     = 1'b0;
      ferr_nxt      = 1'b0;

      if (bus.sample_tick) begin
         unique case (state)
            RX_IDLE: begin
               if (!rx_s) begin
                  state_nxt    = RX_START;
                  tick_cnt_nxt = '0;
               end
            end

            RX_START: begin
               if (tick_cnt == TICK_HALF) begin
                  tick_cnt_nxt = '0;
                  if (!rx_s) begin
                     state_nxt   = RX_DATA;
                     bit_idx_nxt = '0;
                  end else begin
                     state_nxt = RX_IDLE;
                  end
               end else begin
                  tick_cnt_nxt = tick_cnt + TICK_W'(1);
               end
            end

            RX_DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  // Right shift: the first (LSB) bit ends in bit 0.
                  shift_reg_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                  tick_cnt_nxt  = '0;
                  if (bit_idx == BIT_LAST) state_nxt   = RX_STOP;
                  else                     bit_idx_nxt = bit_idx + BIT_W'(1);
               end else begin
                  tick_cnt_nxt = tick_cnt + TICK_W'(1);
               end
            end

            RX_STOP: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_nxt = '0;
                  if (rx_s) begin
                     data_nxt  = shift_reg;
                     valid_nxt = 1'b1;
                     state_nxt = RX_IDLE;
                  end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = RX_BREAK;
                  end
               end else begin
                  tick_cnt_nxt = tick_cnt + TICK_W'(1);
               end
            end

            RX_BREAK: begin
               // Stay here while the line is held low so a break cannot
               // be decoded as a stream of zero frames.
               if (rx_s) state_nxt = RX_IDLE;
            end

            default: begin
               state_nxt = RX_IDLE;
            end
         endcase
      end
   end

   assign bus.data_out    = data_q;
   assign bus.data_valid  = valid_q;
   assign bus.frame_error = ferr_q;
   assign bus.rx_busy     = (state != RX_IDLE);
   assign bus.rx_state    = state;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with hand-computed bytes, a monitor
// that pops expected {frame_error, data_out} entries on every output pulse.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  logic clk;
  logic reset;

  uart_rx_if bus ();

  uart_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic prev_pulse = 1'b0;

  // clock / reset / tick generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    bus.sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
      bus.sample_tick = (div == TICK_DIV - 1);
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bus.rx = v;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.sample_tick) k++;
    end
    #1;
  endtask

  // transmitter model: baud tick is every 16th sample_tick
  task automatic tx_byte(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = frame[i];
      wait_ticks(16);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] got;
    logic [8:0] exp;
    if (bus.data_valid || bus.frame_error) begin
      checks++;
      got = {bus.frame_error, bus.data_out};
      if (bus.data_valid && bus.frame_error) begin
        errors++;
        $display("FAIL pulse_exclusive: data_valid and frame_error both high");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got {ferr,data}=0x%0h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL rx_output: got {ferr,data}=0x%0h expected 0x%0h", got, exp);
        end
      end
      if (prev_pulse) begin
        errors++;
        $display("FAIL pulse_width: pulse high for more than 1 clk, expected 1");
      end
    end
    prev_pulse = bus.data_valid | bus.frame_error;
  end

  // watchdog
  initial begin
    repeat (60000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // directed sequence
  initial begin
    int n;
    bus.rx = 1'b1;
    reset  = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    #1;
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_data_valid", 32'(bus.data_valid), 32'h0);
    check("reset_frame_error", 32'(bus.frame_error), 32'h0);
    check("reset_rx_busy", 32'(bus.rx_busy), 32'h0);
    check("reset_state", 32'(bus.rx_state), 32'(RX_IDLE));
    wait_clk(2 * BIT_CLK);

    // frame 0xA5
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1);
    wait_clk(BIT_CLK);
    check("a5_busy_after", 32'(bus.rx_busy), 32'h0);
    check("a5_data_out", 32'(bus.data_out), 32'hA5);

    // glitch: 4 ticks low
    bus.rx = 1'b0;
    wait_clk(4 * TICK_DIV);
    check("glitch_busy_high", 32'(bus.rx_busy), 32'h1);
    bus.rx = 1'b1;
    n = 0;
    while (bus.rx_busy && n < 40) begin
      wait_clk(1);
      n++;
    end
    check("glitch_busy_fall", 32'(bus.rx_busy), 32'h0);
    wait_clk(BIT_CLK);
    check("glitch_data_out", 32'(bus.data_out), 32'hA5);

    // 0x3C with low stop, held-low break, then 0x81
    exp_q.push_back({1'b1, 8'hA5});
    send_frame(8'h3C, 1'b0);
    bus.rx = 1'b0;
    wait_clk(BIT_CLK + BIT_CLK / 2);
    check("break_state", 32'(bus.rx_state), 32'(RX_BREAK));
    check("break_busy", 32'(bus.rx_busy), 32'h1);
    wait_clk(BIT_CLK + BIT_CLK / 2);
    bus.rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("break_exit_state", 32'(bus.rx_state), 32'(RX_IDLE));
    check("break_data_out", 32'(bus.data_out), 32'hA5);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_clk(BIT_CLK);

    // back-to-back 0x00, 0xFF
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(BIT_CLK);
    check("b2b_data_out", 32'(bus.data_out), 32'hFF);

    // reset after 4 data bits of 0x5A
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(bus.rx_busy), 32'h1);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    #1;
    check("mid_reset_data_out", 32'(bus.data_out), 32'h0);
    check("mid_reset_valid", 32'(bus.data_valid), 32'h0);
    check("mid_reset_ferr", 32'(bus.frame_error), 32'h0);
    check("mid_reset_busy", 32'(bus.rx_busy), 32'h0);
    bus.rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1);
    wait_clk(BIT_CLK);
    check("post_reset_data_out", 32'(bus.data_out), 32'h5A);

    // loopback through transmitter model
    exp_q.push_back({1'b0, 8'h00});
    tx_byte(8'h00);
    exp_q.push_back({1'b0, 8'h55});
    tx_byte(8'h55);
    exp_q.push_back({1'b0, 8'hFF});
    tx_byte(8'hFF);
    exp_q.push_back({1'b0, 8'h7E});
    tx_byte(8'h7E);
    wait_clk(2 * BIT_CLK);
    check("loop_data_out", 32'(bus.data_out), 32'h7E);
    check("loop_busy", 32'(bus.rx_busy), 32'h0);

    // final report
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
